// File: rtl/ser_pkg.sv
// Shared types and default sizing for the byte-to-bit serialiser.
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        SHIFT
    } state_t;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_DIV_W      = 8;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with a registered occupancy count; dout always shows the head word.
module fifo_sync #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/serializador_bits.sv
// Byte-to-bit serialiser: buffered words are shifted out MSB-first at a programmable
// bit period, with a start pulse ahead of each contiguous stream.
module serializador_bits
    import ser_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int DIV_W      = DEF_DIV_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        in_ready,
    input  logic                        enable,
    input  logic [DIV_W-1:0]            div,
    output logic                        start_out,
    output logic                        bit_out,
    output logic                        bit_strobe,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;

    logic              pop;
    logic [DATA_W-1:0] head;
    logic              fifo_full, fifo_empty;

    fifo_sync #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .pop   (pop),
        .din   (in_data),
        .dout  (head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Ready comes straight from the registered level, so a same-cycle pop never frees a slot early.
    assign in_ready = !fifo_full;
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pop        = 1'b0;
        start_out  = 1'b0;
        bit_out    = 1'b0;
        bit_strobe = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = head;
                    div_d   = div;
                    state_d = START;
                end
            end
            START: begin
                start_out = 1'b1;
                cnt_d     = '0;
                idx_d     = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                bit_out    = shreg_q[DATA_W-1];
                bit_strobe = (cnt_q == '0);
                if (cnt_q == div_q) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        // A waiting word continues the stream with no gap and no new start pulse.
                        if (enable && !fifo_empty) begin
                            pop     = 1'b1;
                            shreg_d = head;
                            div_d   = div;
                        end else begin
                            shreg_d = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
        end
    end

endmodule

// File: tb/tb_serializador_bits.sv
// Self-checking bench for serializador_bits: vector table, directed corner cases and random streams.
module tb_serializador_bits;

    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV_W      = 8;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              enable;
    logic [DIV_W-1:0]  div;
    logic              start_out;
    logic              bit_out;
    logic              bit_strobe;
    logic              busy;
    logic [LVL_W-1:0]  fifo_level;

    serializador_bits #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .enable     (enable),
        .div        (div),
        .start_out  (start_out),
        .bit_out    (bit_out),
        .bit_strobe (bit_strobe),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Output monitor: records every strobed bit, start pulses, busy cycles and strobe spacing.
    int mon_cyc    = 0;
    int mon_starts = 0;
    int mon_busy   = 0;
    int mon_last   = 0;
    bit mon_have   = 1'b0;
    int mon_bits[$];
    int mon_gaps[$];

    always @(negedge clk) begin
        mon_cyc <= mon_cyc + 1;
        if (start_out) mon_starts <= mon_starts + 1;
        if (busy) mon_busy <= mon_busy + 1;
        else mon_have <= 1'b0;
        if (bit_strobe) begin
            mon_bits.push_back(int'(bit_out));
            if (mon_have) mon_gaps.push_back(mon_cyc - mon_last);
            mon_last <= mon_cyc;
            mon_have <= 1'b1;
        end
    end

    int b0, g0, s0, u0;
    int last_busy;
    logic [DATA_W-1:0] stim_w [6];

    typedef struct {
        int          dv;
        int          n;
        logic [39:0] words;
        logic [31:0] exp_bits;
        int          exp_len;
        int          exp_busy;
    } vec_t;

    vec_t tv [5];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic snap();
        b0 = mon_bits.size();
        g0 = mon_gaps.size();
        s0 = mon_starts;
        u0 = mon_busy;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_idle(input string nm);
        int guard;
        for (guard = 0; guard < 3000; guard++) begin
            if (!busy) break;
            tick();
        end
        chk(nm, (guard < 3000) ? 1 : 0, 1);
    endtask

    task automatic chk_word(input string nm, input int base, input logic [DATA_W-1:0] w);
        for (int b = 0; b < DATA_W; b++) begin
            if (base + b < mon_bits.size()) chk(nm, mon_bits[base + b], int'(w[DATA_W-1-b]));
            else chk(nm, -1, int'(w[DATA_W-1-b]));
        end
    endtask

    // Queue words with enable low, then release and compare the whole stream to the model.
    task automatic run_stream(input int dv, input int n);
        int acc;
        int exp_q[$];
        int guard;
        bit seen;
        acc    = 0;
        enable = 1'b0;
        div    = DIV_W'(dv);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = stim_w[i];
            if (acc < FIFO_DEPTH) begin
                acc++;
                for (int b = DATA_W - 1; b >= 0; b--) exp_q.push_back(int'(stim_w[i][b]));
            end
            tick();
            chk("push_level", int'(fifo_level), acc);
            chk("push_ready", int'(in_ready), (acc < FIFO_DEPTH) ? 1 : 0);
        end
        in_valid = 1'b0;
        snap();
        enable = 1'b1;
        seen   = 1'b0;
        for (guard = 0; guard < 3000; guard++) begin
            tick();
            if (busy) seen = 1'b1;
            else if (seen) break;
        end
        enable = 1'b0;
        chk("stream_done", (guard < 3000) ? 1 : 0, 1);
        chk("stream_starts", mon_starts - s0, 1);
        chk("stream_nbits", mon_bits.size() - b0, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (b0 + i < mon_bits.size()) chk("stream_bit", mon_bits[b0 + i], exp_q[i]);
        end
        for (int i = g0; i < mon_gaps.size(); i++) chk("stream_gap", mon_gaps[i], dv + 1);
        chk("stream_busy", mon_busy - u0, 1 + DATA_W * acc * (dv + 1));
        chk("stream_level_end", int'(fifo_level), 0);
        last_busy = mon_busy - u0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        tv[0] = '{0, 1, 40'h00_0000_00A5, 32'h0000_00A5, 8, 9};
        tv[1] = '{2, 1, 40'h00_0000_0080, 32'h0000_0080, 8, 25};
        tv[2] = '{0, 2, 40'h00_0000_C33C, 32'h0000_3CC3, 16, 17};
        tv[3] = '{0, 5, 40'h55_4433_2211, 32'h1122_3344, 32, 33};
        tv[4] = '{1, 1, 40'h00_0000_00FF, 32'h0000_00FF, 8, 17};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        enable   = 1'b0;
        div      = '0;
        tick();
        tick();
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_start", int'(start_out), 0);
        chk("rst_bit", int'(bit_out), 0);
        chk("rst_strobe", int'(bit_strobe), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        tick();

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 6; i++) stim_w[i] = (i < 5) ? tv[t].words[8*i +: 8] : '0;
            run_stream(tv[t].dv, tv[t].n);
            chk("tbl_busy", last_busy, tv[t].exp_busy);
            for (int i = 0; i < tv[t].exp_len; i++) begin
                if (b0 + i < mon_bits.size())
                    chk("tbl_bit", mon_bits[b0 + i], int'(tv[t].exp_bits[tv[t].exp_len - 1 - i]));
                else
                    chk("tbl_bit", -1, int'(tv[t].exp_bits[tv[t].exp_len - 1 - i]));
            end
        end

        // Push into an empty FIFO with enable already high.
        enable   = 1'b1;
        div      = '0;
        in_valid = 1'b1;
        in_data  = 8'hC1;
        tick();
        in_valid = 1'b0;
        chk("lat_level", int'(fifo_level), 1);
        chk("lat_no_start_yet", int'(start_out), 0);
        tick();
        chk("lat_start", int'(start_out), 1);
        chk("lat_busy", int'(busy), 1);
        chk("lat_strobe_in_start", int'(bit_strobe), 0);
        tick();
        chk("lat_strobe", int'(bit_strobe), 1);
        chk("lat_first_bit", int'(bit_out), 1);
        chk("lat_start_gone", int'(start_out), 0);
        wait_idle("lat_done");
        chk("lat_bit_idle", int'(bit_out), 0);
        enable = 1'b0;
        tick();

        // Divider changes mid-word must not affect the word in flight.
        div      = 8'd3;
        in_valid = 1'b1;
        in_data  = 8'h6B;
        tick();
        in_valid = 1'b0;
        snap();
        enable = 1'b1;
        tick();
        tick();
        div = '0;
        wait_idle("divchg_done");
        enable = 1'b0;
        chk_word("divchg_bit", b0, 8'h6B);
        for (int i = g0; i < mon_gaps.size(); i++) chk("divchg_gap", mon_gaps[i], 4);
        chk("divchg_busy", mon_busy - u0, 33);
        tick();

        // Asynchronous reset in the middle of bit 3.
        div      = 8'd1;
        enable   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hFF;
        snap();
        tick();
        in_valid = 1'b0;
        for (guard = 0; guard < 200; guard++) begin
            if (mon_bits.size() - b0 >= 4) break;
            tick();
        end
        chk("rst_mid_reached", (guard < 200) ? 1 : 0, 1);
        chk("rst_mid_pre_bit", int'(bit_out), 1);
        chk("rst_mid_pre_busy", int'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_bit", int'(bit_out), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_strobe", int'(bit_strobe), 0);
        chk("rst_mid_start", int'(start_out), 0);
        chk("rst_mid_level", int'(fifo_level), 0);
        chk("rst_mid_ready", int'(in_ready), 1);
        tick();
        rst_n = 1'b1;
        tick();
        snap();
        repeat (20) tick();
        chk("rst_after_bits", mon_bits.size() - b0, 0);
        chk("rst_after_busy", mon_busy - u0, 0);
        chk("rst_after_starts", mon_starts - s0, 0);
        snap();
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        tick();
        wait_idle("rst_new_done");
        chk("rst_new_starts", mon_starts - s0, 1);
        chk_word("rst_new_bit", b0, 8'h5A);
        enable = 1'b0;
        tick();

        // Enable dropped during bit 2 with two more words waiting.
        div = '0;
        stim_w[0] = 8'h96;
        stim_w[1] = 8'h0F;
        stim_w[2] = 8'hE1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = stim_w[i];
            tick();
        end
        in_valid = 1'b0;
        snap();
        enable = 1'b1;
        for (guard = 0; guard < 200; guard++) begin
            tick();
            if (mon_bits.size() - b0 >= 3) break;
        end
        enable = 1'b0;
        wait_idle("endrop_done");
        repeat (3) tick();
        chk("endrop_nbits", mon_bits.size() - b0, 8);
        chk("endrop_starts", mon_starts - s0, 1);
        chk("endrop_level", int'(fifo_level), 2);
        chk("endrop_busy", int'(busy), 0);
        chk_word("endrop_bit", b0, stim_w[0]);
        snap();
        enable = 1'b1;
        tick();
        tick();
        wait_idle("resume_done");
        enable = 1'b0;
        chk("resume_starts", mon_starts - s0, 1);
        chk("resume_nbits", mon_bits.size() - b0, 16);
        chk_word("resume_bit0", b0, stim_w[1]);
        chk_word("resume_bit1", b0 + DATA_W, stim_w[2]);
        chk("resume_level", int'(fifo_level), 0);
        tick();

        // Random streams against the queue model.
        for (int r = 0; r < 12; r++) begin
            int dv, n;
            dv = int'($urandom_range(0, 3));
            n  = int'($urandom_range(1, 6));
            for (int i = 0; i < 6; i++) stim_w[i] = DATA_W'($urandom);
            run_stream(dv, n);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
